// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the multiplexer scan sequencer: state encoding,
// channel count and the channel-to-select mapping.
package mux_scan_sequencer_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef logic [1:0] ch_t;

    // Returns {s0, s1}: s0 carries ch[1], s1 carries ch[0].
    function automatic logic [1:0] ch_to_sel(input ch_t ch);
        return {ch[1], ch[0]};
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// Settle counter: counts enabled cycles from zero and flags when the count
// reaches the programmed limit.
module dwell_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == limit);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 analog/digital mux through all channels, waits a programmable
// settle time on each, captures the returned bit and publishes whole frames.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cont,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output logic [3:0]         sample,
    output logic               frame_valid
);

    state_t             state, state_nx;
    ch_t                ch, ch_nx;
    logic [DWELL_W-1:0] dwell_q, dwell_nx;
    logic               cont_q, cont_nx;
    logic [3:0]         shadow, shadow_nx;
    logic [3:0]         sample_nx;
    logic               tmr_clr, tmr_en, expired;

    dwell_timer #(.W(DWELL_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .limit   (dwell_q),
        .expired (expired)
    );

    always_comb begin
        state_nx  = state;
        ch_nx     = ch;
        dwell_nx  = dwell_q;
        cont_nx   = cont_q;
        shadow_nx = shadow;
        sample_nx = sample;
        tmr_clr   = 1'b1;
        tmr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETTLE;
                    ch_nx    = '0;
                    dwell_nx = dwell;
                    cont_nx  = cont;
                end
            end
            SETTLE: begin
                tmr_clr = expired;
                tmr_en  = 1'b1;
                if (expired) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                shadow_nx[ch] = mux_out;
                if (ch == ch_t'(NUM_CH - 1)) begin
                    state_nx  = DONE;
                    // Publish on DONE entry so sample is stable for the whole pulse.
                    sample_nx = shadow_nx;
                end else begin
                    state_nx = SETTLE;
                    ch_nx    = ch + 2'd1;
                end
            end
            DONE: begin
                ch_nx = '0;
                if (cont_q && !stop) begin
                    state_nx = SETTLE;
                    dwell_nx = dwell;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch          <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
            shadow      <= '0;
            sample      <= '0;
            {s0, s1}    <= '0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            ch          <= ch_nx;
            dwell_q     <= dwell_nx;
            cont_q      <= cont_nx;
            shadow      <= shadow_nx;
            sample      <= sample_nx;
            {s0, s1}    <= (state_nx == IDLE) ? 2'b00 : ch_to_sel(ch_nx);
            busy        <= (state_nx != IDLE);
            frame_valid <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomised scoreboard bench for mux_scan_sequencer: a per-cycle timeline
// model plus a queue of expected frames consumed on every frame_valid pulse.
module tb_mux_scan_sequencer;

    localparam int MAXC = 20000;
    localparam int DC   = 4;   // select value not checked

    logic       clk = 1'b0;
    logic       rst_n, start, cont, stop, mux_out;
    logic [3:0] dwell;
    logic       s0, s1, busy, frame_valid;
    logic [3:0] sample;
    logic [3:0] chan;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit eb [MAXC];
    bit ef [MAXC];
    int es [MAXC];

    typedef struct {
        int         when;
        logic [3:0] smp;
    } frame_t;
    frame_t sbq[$];

    mux_scan_sequencer #(.DWELL_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cont        (cont),
        .stop        (stop),
        .dwell       (dwell),
        .mux_out     (mux_out),
        .s0          (s0),
        .s1          (s1),
        .busy        (busy),
        .sample      (sample),
        .frame_valid (frame_valid)
    );

    // Downstream 4:1 mux: channel k selected by {s0,s1} == k.
    assign mux_out = chan[{s0, s1}];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle timeline check.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            tests++;
            if (busy !== eb[cyc] || frame_valid !== ef[cyc] ||
                (es[cyc] != DC && {s0, s1} !== 2'(es[cyc]))) begin
                fails++;
                $display("FAIL timeline cyc=%0d got busy=%b fv=%b sel=%b%b want busy=%b fv=%b sel=%0d",
                         cyc, busy, frame_valid, s0, s1, eb[cyc], ef[cyc], es[cyc]);
            end
        end
    end

    // Scoreboard monitor: one expected frame per pulse.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL frame_extra cyc=%0d got sample=%b want no pulse", cyc, sample);
            end else begin
                frame_t e;
                e = sbq.pop_front();
                if (e.when != cyc || sample !== e.smp) begin
                    fails++;
                    $display("FAIL frame cyc=%0d sample=%b want cyc=%0d sample=%b",
                             cyc, sample, e.when, e.smp);
                end
            end
        end
    end

    task automatic set_exp(input int n, input bit b, input bit f, input int s);
        if (n >= 0 && n < MAXC) begin
            eb[n] = b;
            ef[n] = f;
            es[n] = s;
        end
    endtask

    // A frame starting at edge t0 spends d+2 edges on each channel, then one DONE.
    task automatic fill_frames(input int t0, input int d, input int nfr);
        int per;
        per = 4 * (d + 2) + 1;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < d + 2; j++)
                    set_exp(t0 + f * per + k * (d + 2) + j, 1'b1, 1'b0, k);
            set_exp(t0 + f * per + 4 * (d + 2), 1'b1, 1'b1, DC);
        end
    endtask

    task automatic do_run(input int d, input int nfr, input bit cnt, input bit perturb,
                          input bit rel_rst, input logic [3:0] chan0);
        logic [3:0] fr [$];
        int t0, per, tend;
        frame_t e;
        @(negedge clk);
        if (rel_rst) rst_n = 1'b1;
        per   = 4 * (d + 2) + 1;
        dwell = 4'(d);
        cont  = cnt;
        stop  = 1'b0;
        start = 1'b1;
        chan  = chan0;
        t0    = cyc + 1;
        fr.push_back(chan0);
        for (int f = 1; f < nfr; f++) fr.push_back(4'($urandom));
        fill_frames(t0, d, nfr);
        for (int f = 0; f < nfr; f++) begin
            e.when = t0 + f * per + 4 * (d + 2);
            e.smp  = fr[f];
            sbq.push_back(e);
        end
        tend = t0 + nfr * per - 1;
        while (cyc < tend + 1) begin
            @(negedge clk);
            if (cyc == t0) begin
                start = 1'b0;
                if (cnt && nfr == 1) stop = 1'b1;
            end
            if (perturb && cyc == t0 + d + 3) begin
                start = 1'b1;
                if (!cnt) begin
                    dwell = 4'($urandom);
                    cont  = 1'b1;
                end
            end
            if (perturb && cyc == t0 + d + 4) start = 1'b0;
            for (int f = 0; f < nfr - 1; f++) begin
                if (cyc == t0 + f * per + 4 * (d + 2)) chan = fr[f + 1];
                if (cyc == t0 + (f + 1) * per && f + 1 == nfr - 1) stop = 1'b1;
            end
        end
        stop = 1'b0;
        cont = 1'b0;
    endtask

    task automatic abort_run(input int d);
        int t0, per, ab;
        @(negedge clk);
        per   = 4 * (d + 2) + 1;
        dwell = 4'(d);
        cont  = 1'b0;
        start = 1'b1;
        chan  = 4'($urandom);
        t0    = cyc + 1;
        fill_frames(t0, d, 1);
        ab = t0 + 2 * (d + 2) + d / 2;
        while (cyc < ab) begin
            @(negedge clk);
            if (cyc == t0) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({s0, s1, busy, frame_valid, sample} !== 8'h00) begin
            fails++;
            $display("FAIL async_reset got s0s1=%b%b busy=%b fv=%b sample=%b want all 0",
                     s0, s1, busy, frame_valid, sample);
        end
        for (int n = ab + 1; n <= t0 + per; n++) set_exp(n, 1'b0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int d, nfr;
        bit cnt;
        for (int i = 0; i < MAXC; i++) begin
            eb[i] = 1'b0;
            ef[i] = 1'b0;
            es[i] = 0;
        end
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        stop  = 1'b0;
        dwell = '0;
        chan  = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (sample !== 4'h0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got sample=%b busy=%b fv=%b want 0 0 0", sample, busy, frame_valid);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(0, 1, 1'b0, 1'b0, 1'b0, 4'b1100);
        do_run(3, 1, 1'b0, 1'b0, 1'b0, 4'($urandom));
        do_run(0, 3, 1'b1, 1'b0, 1'b0, 4'($urandom));
        do_run(2, 1, 1'b0, 1'b1, 1'b0, 4'($urandom));
        do_run(15, 2, 1'b1, 1'b1, 1'b0, 4'($urandom));
        abort_run(int'($urandom_range(0, 4)));
        do_run(0, 1, 1'b0, 1'b0, 1'b1, 4'($urandom));

        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            d   = int'($urandom_range(0, 6));
            nfr = int'($urandom_range(1, 3));
            cnt = (nfr > 1) ? 1'b1 : 1'($urandom);
            do_run(d, nfr, cnt, 1'($urandom), 1'b0, 4'($urandom));
        end

        repeat (5) @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL frames_missing got %0d pending want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
